// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: one requester port of the data-memory arbiter.
//   req/wr/addr/wdata : command from the requester, held until gnt
//   gnt               : combinational accept pulse from the arbiter
//   done/err/rdata    : registered completion pulse, range error, read result
// Modports: master = requester side, slave = arbiter side.
interface dmem_arbiter_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 64
);
  logic              req;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, wr, addr, wdata,
    input  gnt, done, err, rdata
  );

  modport slave (
    input  req, wr, addr, wdata,
    output gnt, done, err, rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port sequencer in front of a single-port
// memory with a 1-cycle registered read.
//   clk, reset_n         : clock, synchronous active-low reset
//   p0, p1               : requester ports (p0 = load/store unit, p1 = debug/DMA)
//   mem_addr/mem_wr/mem_rd/mem_wr_data : memory strobes, driven only in ISSUE
//   mem_rd_data          : memory read data, valid the cycle after mem_rd
module dmem_arbiter #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DEPTH  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  dmem_arbiter_if.slave     p0,
  dmem_arbiter_if.slave     p1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data
);

  typedef enum logic [1:0] {StIdle, StIssue, StRwait, StErr} state_e;

  state_e            state_q, state_d;
  logic              last_q, last_d;      // port granted most recently
  logic              cmd_wr_q;
  logic [ADDR_W-1:0] cmd_addr_q;
  logic [DATA_W-1:0] cmd_wdata_q;
  logic              cmd_port_q;
  logic [1:0]        done_q, done_d;
  logic [1:0]        err_q, err_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic              accept;
  logic              sel;
  logic              sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_oor;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    done_d      = '0;
    err_d       = '0;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    accept      = 1'b0;
    sel         = 1'b0;
    sel_wr      = 1'b0;
    sel_addr    = '0;
    sel_wdata   = '0;
    sel_oor     = 1'b0;
    mem_addr    = '0;
    mem_wr      = 1'b0;
    mem_rd      = 1'b0;
    mem_wr_data = '0;

    unique case (state_q)
      StIdle: begin
        // Gated by reset_n so no grant is shown while reset is asserted.
        if (reset_n && (p0.req || p1.req)) begin
          accept = 1'b1;
          // On a tie the port that did not win last time goes next.
          sel       = (p0.req && p1.req) ? ~last_q : p1.req;
          sel_wr    = sel ? p1.wr    : p0.wr;
          sel_addr  = sel ? p1.addr  : p0.addr;
          sel_wdata = sel ? p1.wdata : p0.wdata;
          sel_oor   = (sel_addr >= ADDR_W'(DEPTH));
          last_d    = sel;
          if (sel_oor) begin
            // Error completes straight from the grant: no memory access.
            state_d     = StErr;
            done_d[sel] = 1'b1;
            err_d[sel]  = 1'b1;
            if (sel) rdata1_d = '0;
            else     rdata0_d = '0;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        mem_addr    = cmd_addr_q;
        mem_wr      = cmd_wr_q;
        mem_rd      = ~cmd_wr_q;
        mem_wr_data = cmd_wdata_q;
        if (cmd_wr_q) begin
          state_d            = StIdle;
          done_d[cmd_port_q] = 1'b1;
        end else begin
          state_d = StRwait;
        end
      end
      StRwait: begin
        state_d            = StIdle;
        done_d[cmd_port_q] = 1'b1;
        if (cmd_port_q) rdata1_d = mem_rd_data;
        else            rdata0_d = mem_rd_data;
      end
      StErr: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      last_q      <= 1'b1;
      cmd_wr_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      cmd_port_q  <= 1'b0;
      done_q      <= '0;
      err_q       <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      if (accept) begin
        cmd_wr_q    <= sel_wr;
        cmd_addr_q  <= sel_addr;
        cmd_wdata_q <= sel_wdata;
        cmd_port_q  <= sel;
      end
    end
  end

  assign p0.gnt   = accept & ~sel;
  assign p1.gnt   = accept & sel;
  assign p0.done  = done_q[0];
  assign p1.done  = done_q[1];
  assign p0.err   = err_q[0];
  assign p1.err   = err_q[1];
  assign p0.rdata = rdata0_q;
  assign p1.rdata = rdata1_q;

endmodule
